// File: rtl/deser32x5.sv
// Bit-to-word deserializer: accepted bits are steered through a 5-bit-addressed
// 1-to-32 demux into a 32-bit accumulator and emitted as a registered word.
module deser32x5 (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_in,
    input  logic        bit_valid,
    output logic        bit_ready,
    input  logic [4:0]  sel,
    input  logic        auto_inc,
    input  logic        flush,
    output logic [31:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [31:0] wr_mask,
    output logic        dbg_state,
    output logic [4:0]  dbg_ptr
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; ready never depends combinationally on the partner's valid.
    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] wr_mask_q, wr_mask_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [31:0] word_out_q, word_out_d;
    logic        word_valid_q, word_valid_d;

    logic        accept;
    logic [4:0]  pos;
    logic [31:0] demux;
    logic [31:0] acc_nxt;
    logic [31:0] mask_nxt;
    logic        complete;

    assign bit_ready = (state_q == COLLECT) && !rst;
    assign accept    = bit_valid && bit_ready;
    assign pos       = auto_inc ? ptr_q : sel;

    // One-hot write strobe: the 1-to-32 demux, gated by the accept event.
    assign demux    = accept ? (32'd1 << pos) : 32'd0;
    assign acc_nxt  = (acc_q & ~demux) | ({32{bit_in}} & demux);
    assign mask_nxt = wr_mask_q | demux;

    assign complete = (state_q == COLLECT) &&
                      ((mask_nxt == 32'hFFFF_FFFF) || (flush && (mask_nxt != 32'd0)));

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        wr_mask_d    = wr_mask_q;
        ptr_d        = ptr_q;
        word_out_d   = word_out_q;
        word_valid_d = word_valid_q;

        case (state_q)
            COLLECT: begin
                if (complete) begin
                    word_out_d   = acc_nxt;
                    word_valid_d = 1'b1;
                    acc_d        = 32'd0;
                    wr_mask_d    = 32'd0;
                    ptr_d        = 5'd0;
                    state_d      = HOLD;
                end else begin
                    acc_d     = acc_nxt;
                    wr_mask_d = mask_nxt;
                    if (accept && auto_inc) begin
                        ptr_d = ptr_q + 5'd1;
                    end
                end
            end
            HOLD: begin
                if (word_valid_q && word_ready) begin
                    word_valid_d = 1'b0;
                    state_d      = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= COLLECT;
            acc_q        <= 32'd0;
            wr_mask_q    <= 32'd0;
            ptr_q        <= 5'd0;
            word_out_q   <= 32'd0;
            word_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            wr_mask_q    <= wr_mask_d;
            ptr_q        <= ptr_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign wr_mask    = wr_mask_q;
    assign dbg_state  = state_q;
    assign dbg_ptr    = ptr_q;

endmodule

// File: tb/tb_deser32x5.sv
// Self-checking bench for deser32x5: directed table, multi-cycle corner
// sequences and a randomised run against a reference model with a word queue.
module tb_deser32x5;

    logic        clk;
    logic        rst;
    logic        bit_in;
    logic        bit_valid;
    logic        bit_ready;
    logic [4:0]  sel;
    logic        auto_inc;
    logic        flush;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] wr_mask;
    logic        dbg_state;
    logic [4:0]  dbg_ptr;

    int total;
    int bad;

    logic [31:0] exp_q[$];

    deser32x5 dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .sel        (sel),
        .auto_inc   (auto_inc),
        .flush      (flush),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .wr_mask    (wr_mask),
        .dbg_state  (dbg_state),
        .dbg_ptr    (dbg_ptr)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        bv;
        logic        bi;
        logic        ai;
        logic [4:0]  s;
        logic        fl;
        logic        wr;
        logic        e_rdy;
        logic        e_wv;
        logic [31:0] e_word;
        logic [31:0] e_mask;
    } vec_t;

    vec_t vecs[10];

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bit_valid  = 1'b0;
        bit_in     = 1'b0;
        auto_inc   = 1'b1;
        sel        = 5'd0;
        flush      = 1'b0;
        word_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_auto(input logic [31:0] w, input int n, input logic wr);
        for (int i = 0; i < n; i++) begin
            bit_valid  = 1'b1;
            auto_inc   = 1'b1;
            bit_in     = w[i];
            flush      = 1'b0;
            word_ready = wr;
            tick();
        end
        bit_valid = 1'b0;
    endtask

    // Completes a word, checks it, then releases it with one handshake.
    task automatic word_and_release(input string name, input logic [31:0] w);
        send_auto(w, 32, 1'b0);
        chk({name, "_wv"}, {31'd0, word_valid}, 32'd1);
        chk({name, "_word"}, word_out, w);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        chk({name, "_rdy_after"}, {31'd0, bit_ready}, 32'd1);
    endtask

    // Reference model state
    logic [31:0] m_acc;
    logic [31:0] m_mask;
    logic [4:0]  m_ptr;
    logic        m_hold;
    logic        m_wv;

    initial begin
        logic [31:0] dup_exp;
        logic [31:0] held;
        logic [4:0]  p;
        total = 0;
        bad   = 0;
        idle_inputs();

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_rdy", {31'd0, bit_ready}, 32'd0);
        chk("rst_wv", {31'd0, word_valid}, 32'd0);
        chk("rst_word", word_out, 32'd0);
        chk("rst_mask", wr_mask, 32'd0);
        chk("rst_ptr", {27'd0, dbg_ptr}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_rel_rdy", {31'd0, bit_ready}, 32'd1);

        // Auto fill with consumer always ready
        send_auto(32'hDEAD_BEEF, 32, 1'b1);
        chk("auto_wv", {31'd0, word_valid}, 32'd1);
        chk("auto_word", word_out, 32'hDEAD_BEEF);
        chk("auto_rdy_low", {31'd0, bit_ready}, 32'd0);
        chk("auto_ptr", {27'd0, dbg_ptr}, 32'd0);
        word_ready = 1'b1;
        tick();
        chk("auto_rdy_back", {31'd0, bit_ready}, 32'd1);
        chk("auto_wv_drop", {31'd0, word_valid}, 32'd0);
        word_ready = 1'b0;

        // Addressed scatter, reverse order, bit = sel[0]
        for (int s = 31; s >= 0; s--) begin
            bit_valid = 1'b1;
            auto_inc  = 1'b0;
            sel       = 5'(s);
            bit_in    = s[0];
            tick();
        end
        bit_valid = 1'b0;
        chk("scatter_wv", {31'd0, word_valid}, 32'd1);
        chk("scatter_word", word_out, 32'hAAAA_AAAA);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;

        // Scatter with a duplicate write of 0 to position 5
        dup_exp = 32'hAAAA_AA8A;
        for (int s = 31; s >= 0; s--) begin
            bit_valid = 1'b1;
            auto_inc  = 1'b0;
            sel       = 5'(s);
            bit_in    = s[0];
            tick();
            if (s == 5) begin
                bit_in = 1'b0;
                tick();
            end
            if (s != 0) chk("dup_no_early_wv", {31'd0, word_valid}, 32'd0);
        end
        bit_valid = 1'b0;
        chk("dup_wv", {31'd0, word_valid}, 32'd1);
        chk("dup_word", word_out, dup_exp);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;

        // Directed table: partial flush, empty flush, mixed-mode flush
        vecs[0] = '{1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h3};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h7};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hD, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hD, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hD, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hD, 32'h0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 32'hD, 32'h80};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h81, 32'h0};
        vecs[9] = '{1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h81, 32'h0};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            bit_valid  = vecs[i].bv;
            bit_in     = vecs[i].bi;
            auto_inc   = vecs[i].ai;
            sel        = vecs[i].s;
            flush      = vecs[i].fl;
            word_ready = vecs[i].wr;
            tick();
            chk($sformatf("vec%0d_rdy", i), {31'd0, bit_ready}, {31'd0, vecs[i].e_rdy});
            chk($sformatf("vec%0d_wv", i), {31'd0, word_valid}, {31'd0, vecs[i].e_wv});
            chk($sformatf("vec%0d_word", i), word_out, vecs[i].e_word);
            chk($sformatf("vec%0d_mask", i), wr_mask, vecs[i].e_mask);
        end
        idle_inputs();

        // Backpressure: word held for 10 cycles while bits are offered
        send_auto(32'h0F0F_1234, 32, 1'b0);
        held = 32'h0F0F_1234;
        for (int i = 0; i < 10; i++) begin
            bit_valid  = 1'b1;
            bit_in     = 1'b1;
            auto_inc   = 1'b1;
            word_ready = 1'b0;
            tick();
            chk("bp_wv", {31'd0, word_valid}, 32'd1);
            chk("bp_word", word_out, held);
            chk("bp_rdy", {31'd0, bit_ready}, 32'd0);
            chk("bp_mask", wr_mask, 32'd0);
        end
        bit_valid  = 1'b0;
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        chk("bp_release_rdy", {31'd0, bit_ready}, 32'd1);
        chk("bp_release_state", {31'd0, dbg_state}, 32'd0);
        word_and_release("bp_next", 32'h55AA_00FF);

        // Reset mid-word after 17 auto bits
        send_auto(32'hFFFF_FFFF, 17, 1'b0);
        chk("mid_mask", wr_mask, 32'h0001_FFFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_mask", wr_mask, 32'd0);
        chk("mid_rst_word", word_out, 32'd0);
        chk("mid_rst_wv", {31'd0, word_valid}, 32'd0);
        chk("mid_rst_ptr", {27'd0, dbg_ptr}, 32'd0);
        word_and_release("mid_fresh", 32'h1234_5678);

        // Reset while holding a word
        send_auto(32'hCAFE_F00D, 32, 1'b0);
        chk("hold_wv", {31'd0, word_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("hold_rst_wv", {31'd0, word_valid}, 32'd0);
        chk("hold_rst_word", word_out, 32'd0);
        chk("hold_rst_state", {31'd0, dbg_state}, 32'd0);
        word_and_release("hold_fresh", 32'h1234_5678);

        // Randomised run against the model
        do_reset();
        m_acc  = 32'd0;
        m_mask = 32'd0;
        m_ptr  = 5'd0;
        m_hold = 1'b0;
        m_wv   = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 10000; c++) begin
            bit_valid  = ($urandom_range(0, 3) != 0);
            bit_in     = 1'($urandom_range(0, 1));
            auto_inc   = 1'($urandom_range(0, 1));
            sel        = 5'($urandom_range(0, 31));
            flush      = ($urandom_range(0, 15) == 0);
            word_ready = 1'($urandom_range(0, 1));
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) chk("rand_q_size", 32'(exp_q.size()), 32'd1);
                else chk("rand_word", word_out, exp_q.pop_front());
            end
            if (!m_hold) begin
                if (bit_valid) begin
                    p = auto_inc ? m_ptr : sel;
                    m_acc[p]  = bit_in;
                    m_mask[p] = 1'b1;
                    if (auto_inc) m_ptr = m_ptr + 5'd1;
                end
                if ((m_mask == 32'hFFFF_FFFF) || (flush && (m_mask != 32'd0))) begin
                    exp_q.push_back(m_acc);
                    m_acc  = 32'd0;
                    m_mask = 32'd0;
                    m_ptr  = 5'd0;
                    m_hold = 1'b1;
                    m_wv   = 1'b1;
                end
            end else if (word_ready) begin
                m_hold = 1'b0;
                m_wv   = 1'b0;
            end
            tick();
            chk("rand_wv", {31'd0, word_valid}, {31'd0, m_wv});
            chk("rand_rdy", {31'd0, bit_ready}, {31'd0, !m_hold});
            chk("rand_mask", wr_mask, m_mask);
        end
        idle_inputs();

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
